// File: rtl/if_pkg.sv
// Shared defaults, entry type and sizing helper for the fetch stage.
package if_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_PC_STEP = 4;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc_next;
    logic [DEF_INSTR_W-1:0] instr;
  } fq_entry_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/if_stage_fq_fetch_fifo.sv
// Synchronous FIFO holding fetched entries; clear empties it in one edge.
module fetch_fifo import if_pkg::*; #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  // Head is masked to zero so an empty queue never leaks stale data.
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/if_stage_fq.sv
// Instruction-fetch stage: PC register, redirect and a decoupled fetch queue to ID.
// Optional fetch/flush statistics counters are enabled by defining IF_FETCH_STATS_EN.
module if_stage_fq import if_pkg::*; #(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                FQ_DEPTH = 4,
  parameter int                PC_STEP  = DEF_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_freeze,
  input  logic               i_br_taken,
  input  logic [ADDR_W-1:0]  i_br_addr,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_data,
  output logic               o_id_valid,
  input  logic               i_id_ready,
  output logic [ADDR_W-1:0]  o_id_pc,
  output logic [INSTR_W-1:0] o_id_instr
`ifdef IF_FETCH_STATS_EN
  ,
  output logic [31:0]        o_stat_fetched,
  output logic [31:0]        o_stat_flushed
`endif
);

  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam int CNT_W   = clog2(FQ_DEPTH) + 1;

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_next;
  logic               w_fetch_en;
  logic               w_pop;
  logic               w_fq_full;
  logic               w_fq_empty;
  logic [CNT_W-1:0]   w_fq_count;
  logic [ENTRY_W-1:0] w_head;

  assign o_imem_addr = r_pc;
  assign w_pc_next   = r_pc + ADDR_W'(PC_STEP);
  // Fullness is judged before this cycle's dequeue, so a full queue skips a fetch.
  assign w_fetch_en  = !i_br_taken && !i_freeze && !w_fq_full;
  assign o_id_valid  = !w_fq_empty;
  assign w_pop       = o_id_valid && i_id_ready;
  assign o_id_pc     = w_head[ENTRY_W-1:INSTR_W];
  assign o_id_instr  = w_head[INSTR_W-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)           r_pc <= RESET_PC;
    else if (i_br_taken) r_pc <= i_br_addr;
    else if (w_fetch_en) r_pc <= w_pc_next;
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_fetch_en),
    .i_pop   (w_pop),
    .i_clear (i_br_taken),
    .i_data  ({w_pc_next, i_imem_data}),
    .o_data  (w_head),
    .o_full  (w_fq_full),
    .o_empty (w_fq_empty),
    .o_count (w_fq_count)
  );

`ifdef IF_FETCH_STATS_EN
  logic [31:0]      r_stat_fetched;
  logic [31:0]      r_stat_flushed;
  logic [CNT_W-1:0] w_flush_n;
  logic [32:0]      w_fetched_sum;
  logic [32:0]      w_flushed_sum;

  // A same-cycle dequeue completes normally, so it is not counted as flushed.
  assign w_flush_n     = w_fq_count - CNT_W'(w_pop);
  assign w_fetched_sum = {1'b0, r_stat_fetched} + 33'(1);
  assign w_flushed_sum = {1'b0, r_stat_flushed} + 33'(w_flush_n);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stat_fetched <= '0;
      r_stat_flushed <= '0;
    end else begin
      if (w_fetch_en) r_stat_fetched <= w_fetched_sum[32] ? '1 : w_fetched_sum[31:0];
      if (i_br_taken) r_stat_flushed <= w_flushed_sum[32] ? '1 : w_flushed_sum[31:0];
    end
  end

  assign o_stat_fetched = r_stat_fetched;
  assign o_stat_flushed = r_stat_flushed;
`else
  logic w_unused_count;
  assign w_unused_count = ^w_fq_count;
`endif

endmodule

// File: tb/tb_if_stage_fq.sv
// Scoreboard bench for if_stage_fq with an 8-bit PC so address wrap is exercised.
module tb_if_stage_fq;

  localparam int              AW    = 8;
  localparam int              IW    = 32;
  localparam int              DEPTH = 4;
  localparam int              STEP  = 4;
  localparam logic [AW-1:0]   RPC   = 8'h00;

  typedef struct {
    logic [AW-1:0] pcNext;
    logic [IW-1:0] instr;
  } expEntry_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          freeze = 1'b0;
  logic          brTaken = 1'b0;
  logic          idReady = 1'b0;
  logic [AW-1:0] brAddr = '0;
  logic [AW-1:0] imemAddr;
  logic [IW-1:0] imemData;
  logic          idValid;
  logic [AW-1:0] idPc;
  logic [IW-1:0] idInstr;
`ifdef IF_FETCH_STATS_EN
  logic [31:0]   statFetched;
  logic [31:0]   statFlushed;
`endif

  expEntry_t     sbQ[$];
  logic [AW-1:0] mPc = RPC;
  longint        mFetched = 0;
  longint        mFlushed = 0;
  int            nVectors = 0;
  int            nMiscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] imemWord(input logic [AW-1:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  assign imemData = imemWord(imemAddr);

  if_stage_fq #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .FQ_DEPTH (DEPTH),
    .PC_STEP  (STEP),
    .RESET_PC (RPC)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_freeze    (freeze),
    .i_br_taken  (brTaken),
    .i_br_addr   (brAddr),
    .o_imem_addr (imemAddr),
    .i_imem_data (imemData),
    .o_id_valid  (idValid),
    .i_id_ready  (idReady),
    .o_id_pc     (idPc),
    .o_id_instr  (idInstr)
`ifdef IF_FETCH_STATS_EN
    ,
    .o_stat_fetched (statFetched),
    .o_stat_flushed (statFlushed)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compare DUT outputs with the expected queue head and retire on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        checkOutput("imem_addr", imemAddr, mPc);
        checkOutput("id_valid", idValid, sbQ.size() != 0);
        if (sbQ.size() != 0) begin
          checkOutput("id_pc", idPc, sbQ[0].pcNext);
          checkOutput("id_instr", idInstr, sbQ[0].instr);
          if (idReady) void'(sbQ.pop_front());
        end else begin
          checkOutput("id_pc_masked", idPc, 0);
          checkOutput("id_instr_masked", idInstr, 0);
        end
      end
    end
  end

  // One cycle of stimulus; the expected effect of the coming edge is applied after the monitor ran.
  task automatic applyStimulus(input logic f, input logic b, input logic [AW-1:0] ba, input logic r);
    bit            doFetch;
    logic [AW-1:0] nxt;
    @(negedge clk);
    #1;
    freeze  = f;
    brTaken = b;
    brAddr  = ba;
    idReady = r;
    doFetch = !b && !f && (sbQ.size() < DEPTH);
    #3;
    if (b) begin
      mFlushed += sbQ.size();
      sbQ.delete();
      mPc = ba;
    end else if (doFetch) begin
      nxt = mPc + AW'(STEP);
      sbQ.push_back('{nxt, imemWord(mPc)});
      mPc = nxt;
      mFetched++;
    end
  endtask

  task automatic releaseReset();
    @(negedge clk);
    #1;
    freeze  = 1'b1;
    brTaken = 1'b0;
    idReady = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, idValid, 0);
    checkOutput({tag, "_imem_addr"}, imemAddr, RPC);
    checkOutput({tag, "_id_pc"}, idPc, 0);
    checkOutput({tag, "_id_instr"}, idInstr, 0);
  endtask

  initial begin
    $display("[TB] starting if_stage_fq scoreboard run");
    repeat (2) @(negedge clk);
    #2;
    checkResetState("reset");
    releaseReset();

    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 8'h00, 0);
    #2;
    checkOutput("stall_pc", imemAddr, 8'd16);
    checkOutput("stall_valid", idValid, 1);

    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 8'h00, 1);

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 8'h00, 1);

    applyStimulus(0, 1, 8'h40, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h00, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 1);
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 0, 8'h00, 0);
    applyStimulus(1, 0, 8'h00, 1);
    applyStimulus(0, 1, 8'h00, 1);
    applyStimulus(0, 0, 8'h00, 1);

    applyStimulus(1, 1, 8'h80, 1);
    applyStimulus(1, 0, 8'h00, 1);
    applyStimulus(1, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 1);

    applyStimulus(0, 1, 8'hF4, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 8'h00, 1);

    for (int i = 0; i < 1500; i++)
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                    8'($urandom), $urandom_range(0, 9) < 7);

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 0);
    @(negedge clk);
    #7;
    rst = 1'b1;
    #1;
    checkResetState("async_reset");
    sbQ.delete();
    mPc      = RPC;
    mFetched = 0;
    mFlushed = 0;
    releaseReset();
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 8'h00, 1);

`ifdef IF_FETCH_STATS_EN
    #2;
    checkOutput("stat_fetched", statFetched, mFetched);
    checkOutput("stat_flushed", statFlushed, mFlushed);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
